// File: rtl/oursring_pkg.sv
// Shared ring-bus types: AXI response codes and their width.
package oursring_pkg;

  localparam int unsigned RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/oursring_idx_fifo.sv
// Small FIFO of master-port indices, one entry per outstanding transaction.
module oursring_idx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/oursring_resp_router.sv
// Records AW/AR grant order per master port and steers B/R responses back to the granted port.
module oursring_resp_router
  import oursring_pkg::*;
#(
  parameter int unsigned N_IN_PORT    = 3,
  parameter int unsigned OUTSTD_DEPTH = 4,
  parameter int unsigned DATA_W       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN_PORT-1:0] aw_hs,
  input  logic [N_IN_PORT-1:0] ar_hs,
  output logic                 aw_block,
  output logic                 ar_block,
  input  logic                 o_bvalid,
  output logic                 o_bready,
  input  logic [RESP_W-1:0]    o_bresp,
  input  logic                 o_rvalid,
  output logic                 o_rready,
  input  logic [DATA_W-1:0]    o_rdata,
  input  logic [RESP_W-1:0]    o_rresp,
  input  logic                 o_rlast,
  output logic [N_IN_PORT-1:0] i_bvalid,
  input  logic [N_IN_PORT-1:0] i_bready,
  output logic [RESP_W-1:0]    i_bresp,
  output logic [N_IN_PORT-1:0] i_rvalid,
  input  logic [N_IN_PORT-1:0] i_rready,
  output logic [DATA_W-1:0]    i_rdata,
  output logic [RESP_W-1:0]    i_rresp,
  output logic                 i_rlast,
  output logic                 err_sticky
);

  localparam int unsigned IDX_W = $clog2(N_IN_PORT);
  localparam int unsigned CNT_W = $clog2(OUTSTD_DEPTH + 1);

  logic             aw_one, ar_one;
  logic             aw_bad, ar_bad;
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             w_full, w_empty, r_full, r_empty;
  logic [CNT_W-1:0] w_count, r_count;
  logic [IDX_W-1:0] w_head, r_head;
  logic             b_pop, r_pop;
  logic             err_set;

  // Handshake legality: only a single-port grant is tracked.
  assign aw_one = $onehot(aw_hs);
  assign ar_one = $onehot(ar_hs);
  assign aw_bad = (|aw_hs) & ~aw_one;
  assign ar_bad = (|ar_hs) & ~ar_one;

  // One-hot to index encoders for the grant vectors.
  always_comb begin
    aw_idx = '0;
    ar_idx = '0;
    for (int unsigned i = 0; i < N_IN_PORT; i++) begin
      if (aw_hs[i]) aw_idx = IDX_W'(i);
      if (ar_hs[i]) ar_idx = IDX_W'(i);
    end
  end

  oursring_idx_fifo #(.DEPTH(OUTSTD_DEPTH), .W(IDX_W)) u_w_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_one),
    .pop   (b_pop),
    .din   (aw_idx),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  oursring_idx_fifo #(.DEPTH(OUTSTD_DEPTH), .W(IDX_W)) u_r_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ar_one),
    .pop   (r_pop),
    .din   (ar_idx),
    .full  (r_full),
    .empty (r_empty),
    .count (r_count),
    .head  (r_head)
  );

  assign aw_block = (w_count == CNT_W'(OUTSTD_DEPTH));
  assign ar_block = (r_count == CNT_W'(OUTSTD_DEPTH));

  // B steering to the oldest outstanding writer; an empty tracker stalls the egress.
  always_comb begin
    i_bvalid = '0;
    o_bready = 1'b0;
    if (!w_empty) begin
      for (int unsigned i = 0; i < N_IN_PORT; i++) begin
        if (w_head == IDX_W'(i)) begin
          i_bvalid[i] = o_bvalid;
          o_bready    = i_bready[i];
        end
      end
    end
  end

  // R steering to the oldest outstanding reader; head holds for the whole burst.
  always_comb begin
    i_rvalid = '0;
    o_rready = 1'b0;
    if (!r_empty) begin
      for (int unsigned i = 0; i < N_IN_PORT; i++) begin
        if (r_head == IDX_W'(i)) begin
          i_rvalid[i] = o_rvalid;
          o_rready    = i_rready[i];
        end
      end
    end
  end

  assign b_pop = o_bvalid & o_bready;
  assign r_pop = o_rvalid & o_rready & o_rlast;

  assign i_bresp = o_bresp;
  assign i_rdata = o_rdata;
  assign i_rresp = o_rresp;
  assign i_rlast = o_rlast;

  assign err_set = aw_bad | ar_bad
                 | (aw_one & w_full) | (ar_one & r_full)
                 | (o_bvalid & w_empty) | (o_rvalid & r_empty);

  // Protocol error flag, held until reset.
  always_ff @(posedge clk) begin
    if (rst) err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_oursring_resp_router.sv
// Bench for oursring_resp_router: directed table plus random traffic against a queue model.
module tb_oursring_resp_router;

  localparam int unsigned N  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  aw_hs, ar_hs;
  logic          aw_block, ar_block;
  logic          o_bvalid, o_bready;
  logic [1:0]    o_bresp;
  logic          o_rvalid, o_rready;
  logic [DW-1:0] o_rdata;
  logic [1:0]    o_rresp;
  logic          o_rlast;
  logic [N-1:0]  i_bvalid, i_bready;
  logic [1:0]    i_bresp;
  logic [N-1:0]  i_rvalid, i_rready;
  logic [DW-1:0] i_rdata;
  logic [1:0]    i_rresp;
  logic          i_rlast;
  logic          err_sticky;

  oursring_resp_router #(.N_IN_PORT(N), .OUTSTD_DEPTH(D), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .aw_hs(aw_hs), .ar_hs(ar_hs),
    .aw_block(aw_block), .ar_block(ar_block),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bresp(o_bresp),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rdata(o_rdata),
    .o_rresp(o_rresp), .o_rlast(o_rlast),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bresp(i_bresp),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rdata(i_rdata),
    .i_rresp(i_rresp), .i_rlast(i_rlast), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [2:0] aw, ar;
    logic       bv, rv, rl;
    logic [2:0] br, rr;
    logic [2:0] e_bv, e_rv;
    logic       e_bo, e_ro, e_awb, e_arb, e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: queues of granted port numbers, oldest first.
  int wq[$];
  int rq[$];
  bit m_err;

  task automatic add(input logic r, input logic [2:0] aw, ar, input logic bv, rv, rl,
                     input logic [2:0] br, rr, e_bv, e_rv,
                     input logic e_bo, e_ro, e_awb, e_arb, e_err);
    vec_t v;
    v.r = r; v.aw = aw; v.ar = ar; v.bv = bv; v.rv = rv; v.rl = rl;
    v.br = br; v.rr = rr; v.e_bv = e_bv; v.e_rv = e_rv;
    v.e_bo = e_bo; v.e_ro = e_ro; v.e_awb = e_awb; v.e_arb = e_arb; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic check_model(input int tag);
    logic [2:0]  ebv, erv;
    logic        ebo, ero;
    logic [10:0] exp_v, act_v;
    logic [68:0] exp_bc, act_bc;
    ebv = '0; erv = '0; ebo = 1'b0; ero = 1'b0;
    if (wq.size() > 0) begin
      ebv = o_bvalid ? 3'(1 << wq[0]) : 3'b000;
      ebo = i_bready[wq[0]];
    end
    if (rq.size() > 0) begin
      erv = o_rvalid ? 3'(1 << rq[0]) : 3'b000;
      ero = i_rready[rq[0]];
    end
    exp_v = {ebv, ebo, erv, ero, wq.size() == D, rq.size() == D, m_err};
    act_v = {i_bvalid, o_bready, i_rvalid, o_rready, aw_block, ar_block, err_sticky};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model tag=%0d got=%b want=%b (bv,bo,rv,ro,awb,arb,err)", tag, act_v, exp_v);
    end
    exp_bc = {o_bresp, o_rdata, o_rresp, o_rlast};
    act_bc = {i_bresp, i_rdata, i_rresp, i_rlast};
    n_cmp++;
    if (act_bc !== exp_bc) begin
      n_bad++;
      $display("FAIL bcast tag=%0d got=%h want=%h", tag, act_bc, exp_bc);
    end
  endtask

  task automatic check_tbl(input vec_t v, input int tag);
    logic [10:0] exp_v, act_v;
    exp_v = {v.e_bv, v.e_bo, v.e_rv, v.e_ro, v.e_awb, v.e_arb, v.e_err};
    act_v = {i_bvalid, o_bready, i_rvalid, o_rready, aw_block, ar_block, err_sticky};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL table vec=%0d got=%b want=%b (bv,bo,rv,ro,awb,arb,err)", tag, act_v, exp_v);
    end
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_update();
    int wsz, rsz;
    bit bpop, rpop;
    if (rst) begin
      wq.delete(); rq.delete(); m_err = 1'b0;
    end else begin
      wsz  = wq.size();
      rsz  = rq.size();
      bpop = o_bvalid && wsz > 0 && i_bready[wq[0]];
      rpop = o_rvalid && rsz > 0 && i_rready[rq[0]] && o_rlast;
      if ($countones(aw_hs) > 1) m_err = 1'b1;
      if ($countones(ar_hs) > 1) m_err = 1'b1;
      if ($countones(aw_hs) == 1 && wsz == D) m_err = 1'b1;
      if ($countones(ar_hs) == 1 && rsz == D) m_err = 1'b1;
      if (o_bvalid && wsz == 0) m_err = 1'b1;
      if (o_rvalid && rsz == 0) m_err = 1'b1;
      if (bpop) void'(wq.pop_front());
      if (rpop) void'(rq.pop_front());
      if ($countones(aw_hs) == 1 && wsz < D) wq.push_back($clog2(aw_hs));
      if ($countones(ar_hs) == 1 && rsz < D) rq.push_back($clog2(ar_hs));
    end
  endtask

  task automatic step(input bit use_tbl, input vec_t v, input int tag);
    #3;
    if (!rst) begin
      check_model(tag);
      if (use_tbl) check_tbl(v, tag);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t none;
    int   r;
    none = '{default: '0};
    rst = 1'b1; aw_hs = '0; ar_hs = '0;
    o_bvalid = 1'b0; o_bresp = '0; o_rvalid = 1'b0; o_rdata = '0; o_rresp = '0; o_rlast = 1'b0;
    i_bready = '0; i_rready = '0;

    //   r aw ar bv rv rl br rr  | ebv erv bo ro awb arb err
    add(1, 0, 0, 0, 0, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0);
    // grant order 2 then 0, B returns in that order
    add(0, 4, 0, 0, 0, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 7, 7,  4, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 7, 7,  1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0);
    // 4-beat read burst to port 1, stall on beat 2
    add(0, 0, 2, 0, 0, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 7, 7,  0, 2, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 7, 5,  0, 2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 7, 7,  0, 2, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 7, 7,  0, 2, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 7, 7,  0, 2, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 7, 7,  0, 0, 0, 0, 0, 0, 0);
    // fill write tracker, then overflow
    add(0, 1, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 0, 0, 0);
    add(0, 4, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 1, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 7, 7,  1, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    // simultaneous push and pop at count 2
    add(0, 4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 7, 0,  4, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 7, 0,  2, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 7, 0,  1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 0);
    // B on empty tracker
    add(0, 0, 0, 1, 0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    // non-one-hot grant is not tracked
    add(0, 3, 0, 0, 0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 7, 7,  0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst = v.r; aw_hs = v.aw; ar_hs = v.ar;
      o_bvalid = v.bv; o_rvalid = v.rv; o_rlast = v.rl;
      i_bready = v.br; i_rready = v.rr;
      o_rdata = {$urandom, $urandom}; o_bresp = 2'($urandom); o_rresp = 2'($urandom);
      step(1'b1, v, i);
    end

    // Random traffic with periodic reset.
    for (int i = 0; i < 3000; i++) begin
      rst = (i % 300) < 2;
      r = $urandom_range(0, 99);
      if (r < 50) aw_hs = '0;
      else if (r < 97) aw_hs = 3'(1 << $urandom_range(0, 2));
      else aw_hs = 3'($urandom);
      r = $urandom_range(0, 99);
      if (r < 50) ar_hs = '0;
      else if (r < 97) ar_hs = 3'(1 << $urandom_range(0, 2));
      else ar_hs = 3'($urandom);
      if (wq.size() == D && $urandom_range(0, 9) != 0) aw_hs = '0;
      if (rq.size() == D && $urandom_range(0, 9) != 0) ar_hs = '0;
      o_bvalid = (wq.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 49) == 0);
      o_rvalid = (rq.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 49) == 0);
      o_rlast  = $urandom_range(0, 3) == 0;
      i_bready = ($urandom_range(0, 9) < 7) ? 3'b111 : 3'($urandom);
      i_rready = ($urandom_range(0, 9) < 7) ? 3'b111 : 3'($urandom);
      o_rdata = {$urandom, $urandom}; o_bresp = 2'($urandom); o_rresp = 2'($urandom);
      step(1'b0, none, 1000 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
